// File: rtl/alu_issue_stage_if.sv
// Decoder-to-ALU issue bundle: decoded fields and operands in, ALU operands out, plus the
// writeback forwarding port. The stage uses the slave modport; its environment uses master.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_IDX_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op_type;
    logic [2:0]           funct3;
    logic                 funct7_b5;
    logic                 use_pc;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 fwd_valid;
    logic [REG_IDX_W-1:0] fwd_rd;
    logic [XLEN-1:0]      fwd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      alu_in1;
    logic [XLEN-1:0]      alu_in2;
    logic [3:0]           alu_control;
    logic [REG_IDX_W-1:0] out_rd;
    logic                 out_is_branch;
    logic [2:0]           out_funct3;

    modport master (
        output in_valid, op_type, funct3, funct7_b5, use_pc, rs1_idx, rs2_idx, rs1_val, rs2_val,
               imm, pc, rd_idx, fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, alu_in1, alu_in2, alu_control, out_rd, out_is_branch,
               out_funct3
    );

    modport slave (
        input  in_valid, op_type, funct3, funct7_b5, use_pc, rs1_idx, rs2_idx, rs1_val, rs2_val,
               imm, pc, rd_idx, fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, alu_in1, alu_in2, alu_control, out_rd, out_is_branch,
               out_funct3
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue register with a 2-entry (OUT + SKID) buffer, operand select and ALU control build.
// Optional writeback forwarding into captured and held entries: ALU_ISSUE_FORWARD_EN.
module alu_issue_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_IDX_W = 5
) (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    alu_issue_stage_if.slave bus
);
    localparam logic [1:0] OpR    = 2'd0;
    localparam logic [1:0] OpI    = 2'd1;
    localparam logic [1:0] OpBr   = 2'd2;
    localparam logic [1:0] OpAddr = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]      in1;
        logic [XLEN-1:0]      in2;
        logic [3:0]           ctrl;
        logic [REG_IDX_W-1:0] rd;
        logic                 is_branch;
        logic [2:0]           funct3;
`ifdef ALU_ISSUE_FORWARD_EN
        logic [REG_IDX_W-1:0] rs1_idx;
        logic [REG_IDX_W-1:0] rs2_idx;
        logic                 use_rs1;
        logic                 use_rs2;
`endif
    } entry_t;

    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    entry_t in_entry, in_fwd, out_fwd, skid_fwd;
    logic   [3:0] ctrl;
    logic   sel_pc, sel_rs2, accept, out_fire;

    assign sel_pc  = (bus.op_type == OpAddr) && bus.use_pc;
    assign sel_rs2 = (bus.op_type == OpR) || (bus.op_type == OpBr);

    always_comb begin
        ctrl = 4'b0000;
        unique case (bus.op_type)
            OpR:    ctrl = {bus.funct7_b5, bus.funct3};
            OpI:    ctrl = (bus.funct3 == 3'b101) ? {bus.funct7_b5, 3'b101} : {1'b0, bus.funct3};
            OpBr: begin
                // beq/bne compare via sub; blt/bge via slt; bltu/bgeu via sltu
                case (bus.funct3[2:1])
                    2'b00:   ctrl = 4'b1000;
                    2'b10:   ctrl = 4'b0010;
                    2'b11:   ctrl = 4'b0011;
                    default: ctrl = 4'b0000;
                endcase
            end
            OpAddr: ctrl = 4'b0000;
            default: ctrl = 4'b0000;
        endcase
    end

    always_comb begin
        in_entry           = '0;
        in_entry.in1       = sel_pc ? bus.pc : bus.rs1_val;
        in_entry.in2       = sel_rs2 ? bus.rs2_val : bus.imm;
        in_entry.ctrl      = ctrl;
        in_entry.rd        = bus.rd_idx;
        in_entry.is_branch = (bus.op_type == OpBr);
        in_entry.funct3    = bus.funct3;
`ifdef ALU_ISSUE_FORWARD_EN
        in_entry.rs1_idx   = bus.rs1_idx;
        in_entry.rs2_idx   = bus.rs2_idx;
        in_entry.use_rs1   = !sel_pc;
        in_entry.use_rs2   = sel_rs2;
`endif
    end

`ifdef ALU_ISSUE_FORWARD_EN
    function automatic entry_t apply_fwd(entry_t e, logic v, logic [REG_IDX_W-1:0] rd,
                                         logic [XLEN-1:0] data);
        entry_t r;
        r = e;
        if (v && (rd != '0)) begin
            if (e.use_rs1 && (e.rs1_idx == rd)) r.in1 = data;
            if (e.use_rs2 && (e.rs2_idx == rd)) r.in2 = data;
        end
        return r;
    endfunction

    // Held entries keep snooping writeback so a stalled operand never goes stale.
    assign in_fwd   = apply_fwd(in_entry, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    assign out_fwd  = apply_fwd(out_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    assign skid_fwd = apply_fwd(skid_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
`else
    assign in_fwd   = in_entry;
    assign out_fwd  = out_q;
    assign skid_fwd = skid_q;

    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data, bus.rs1_idx, bus.rs2_idx};
`endif

    assign accept   = bus.in_valid && !skid_valid_q;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        out_d        = out_fwd;
        skid_d       = skid_fwd;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_d        = skid_fwd;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_fwd;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_fwd;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready      = !skid_valid_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_in1       = out_q.in1;
    assign bus.alu_in2       = out_q.in2;
    assign bus.alu_control   = out_q.ctrl;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_is_branch = out_q.is_branch;
    assign bus.out_funct3    = out_q.funct3;
endmodule
